// File: rtl/inst_fetch_port.sv
// Instruction-fetch responder: walks a byte-wide synchronous memory over four
// consecutive addresses and presents the little-endian 32-bit word to IF/ID.
module inst_fetch_port #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [7:0]        mem_data_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  output logic              stallreq_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [7:0]        byte0, byte1, byte2;
  logic              busy;
  logic              accept;
  logic              abort;

  assign busy   = (state == S1) || (state == S2) || (state == S3) || (state == S4);
  assign accept = (state == IDLE) && ce_i && !flush_i;
  // Dropping ce mid-fetch cancels the fetch just like a flush does.
  assign abort  = busy && (flush_i || !ce_i);

  always_comb begin
    state_nxt    = state;
    mem_addr_o   = '0;
    mem_rd_o     = 1'b0;
    stallreq_o   = 1'b0;
    inst_valid_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          mem_addr_o = pc_i;
          mem_rd_o   = 1'b1;
          stallreq_o = 1'b1;
          state_nxt  = S1;
        end
      end
      S1: begin
        mem_addr_o = fetch_pc + ADDR_W'(1);
        mem_rd_o   = 1'b1;
        stallreq_o = 1'b1;
        state_nxt  = S2;
      end
      S2: begin
        mem_addr_o = fetch_pc + ADDR_W'(2);
        mem_rd_o   = 1'b1;
        stallreq_o = 1'b1;
        state_nxt  = S3;
      end
      S3: begin
        mem_addr_o = fetch_pc + ADDR_W'(3);
        mem_rd_o   = 1'b1;
        stallreq_o = 1'b1;
        state_nxt  = S4;
      end
      S4: begin
        stallreq_o = 1'b1;
        state_nxt  = DONE;
      end
      DONE: begin
        inst_valid_o = !flush_i;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush_i || abort) state_nxt = IDLE;
    // Outputs are quiet while reset is held, whatever state is being left.
    if (rst) begin
      mem_addr_o   = '0;
      mem_rd_o     = 1'b0;
      stallreq_o   = 1'b0;
      inst_valid_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= '0;
      byte0     <= '0;
      byte1     <= '0;
      byte2     <= '0;
      inst_o    <= NOP_INST;
      inst_pc_o <= '0;
    end else begin
      if (accept) fetch_pc <= pc_i;
      if (abort) begin
        byte0 <= '0;
        byte1 <= '0;
        byte2 <= '0;
      end else begin
        // Each byte arrives one cycle after its address was issued.
        unique case (state)
          S1: byte0 <= mem_data_i;
          S2: byte1 <= mem_data_i;
          S3: byte2 <= mem_data_i;
          S4: begin
            inst_o    <= {mem_data_i, byte2, byte1, byte0};
            inst_pc_o <= fetch_pc;
          end
          default: ;
        endcase
      end
      if (flush_i) begin
        inst_o <= NOP_INST;
        byte0  <= '0;
        byte1  <= '0;
        byte2  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_port.sv
// Bench for inst_fetch_port: directed vector table followed by randomized
// traffic checked against a transaction-level reference model.
module tb_inst_fetch_port;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, ce, flush;
  logic [31:0] pc, mem_addr, inst, inst_pc;
  logic        mem_rd, inst_valid, stallreq;
  logic [7:0]  mem_data;

  int checks = 0;
  int errors = 0;

  inst_fetch_port #(.ADDR_W(32), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .pc_i(pc), .ce_i(ce), .flush_i(flush),
    .mem_addr_o(mem_addr), .mem_rd_o(mem_rd), .mem_data_i(mem_data),
    .inst_o(inst), .inst_pc_o(inst_pc), .inst_valid_o(inst_valid),
    .stallreq_o(stallreq)
  );

  always #5 clk = ~clk;

  logic [7:0] img [bit [31:0]];

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (img.exists(a)) return img[a];
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] p);
    return {mem_byte(p + 32'd3), mem_byte(p + 32'd2), mem_byte(p + 32'd1), mem_byte(p)};
  endfunction

  // Synchronous byte memory: data one cycle after the read strobe.
  always @(posedge clk) mem_data <= mem_rd ? mem_byte(mem_addr) : 8'hEE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        r, c, f;
    logic [31:0] p;
    logic        rd;
    logic [31:0] a;
    logic        st, v;
    logic [31:0] i, ip;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic c, input logic f, input logic [31:0] p,
                     input logic rd, input logic [31:0] a, input logic st, input logic v,
                     input logic [31:0] i, input logic [31:0] ip);
    vec_t e;
    e.r = r; e.c = c; e.f = f; e.p = p; e.rd = rd; e.a = a; e.st = st; e.v = v;
    e.i = i; e.ip = ip;
    tbl.push_back(e);
  endtask

  // Accept cycle plus S1..S4 for a fetch from p while inst/inst_pc hold i/ip.
  task automatic fetch_rows(input logic [31:0] p, input logic [31:0] i, input logic [31:0] ip);
    for (int k = 0; k < 4; k++) add(0, 1, 0, p, 1, p + k, 1, 0, i, ip);
    add(0, 1, 0, p, 0, 0, 1, 0, i, ip);
  endtask

  task automatic compare_outputs(input string tag, input logic rd, input logic [31:0] a,
                                 input logic st, input logic v, input logic [31:0] i,
                                 input logic [31:0] ip);
    chk({tag, " mem_rd"}, {31'd0, mem_rd}, {31'd0, rd});
    chk({tag, " mem_addr"}, mem_addr, a);
    chk({tag, " stallreq"}, {31'd0, stallreq}, {31'd0, st});
    chk({tag, " inst_valid"}, {31'd0, inst_valid}, {31'd0, v});
    chk({tag, " inst"}, inst, i);
    chk({tag, " inst_pc"}, inst_pc, ip);
  endtask

  logic [31:0] w0, w4, w40, wf;

  // Reference model state: phase = cycles since the fetch was accepted, -1 = none.
  int          phase;
  logic [31:0] m_pc, m_inst, m_ipc;
  logic        r_r, r_c, r_f;
  logic [31:0] r_p;
  logic        e_rd, e_st, e_v;
  logic [31:0] e_a;

  initial begin
    {img[0], img[1], img[2], img[3]} = {8'h13, 8'h05, 8'h50, 8'h00};
    {img[4], img[5], img[6], img[7]} = {8'h93, 8'h05, 8'hA0, 8'h00};
    w0  = 32'h00500513;
    w4  = 32'h00A00593;
    w40 = word_at(32'h40);
    wf  = word_at(32'hFFFFFFFE);

    rst = 1; ce = 0; flush = 0; pc = 0;
    @(posedge clk); #1;

    add(1, 0, 0, 0, 0, 0, 0, 0, NOP, 0);
    repeat (3) add(0, 0, 0, 0, 0, 0, 0, 0, NOP, 0);
    fetch_rows(32'h0, NOP, 0);
    add(0, 1, 0, 4, 0, 0, 0, 1, w0, 0);
    fetch_rows(32'h4, w0, 0);
    add(0, 0, 0, 4, 0, 0, 0, 1, w4, 4);
    add(0, 1, 0, 8, 1, 8, 1, 0, w4, 4);
    add(0, 1, 0, 8, 1, 9, 1, 0, w4, 4);
    add(0, 1, 1, 8, 1, 10, 1, 0, w4, 4);
    add(0, 0, 0, 8, 0, 0, 0, 0, NOP, 4);
    fetch_rows(32'h40, NOP, 4);
    add(0, 0, 0, 32'h40, 0, 0, 0, 1, w40, 32'h40);
    add(0, 1, 1, 32'h80, 0, 0, 0, 0, w40, 32'h40);
    add(0, 0, 0, 0, 0, 0, 0, 0, NOP, 32'h40);
    fetch_rows(32'hFFFFFFFE, NOP, 32'h40);
    add(0, 0, 0, 0, 0, 0, 0, 1, wf, 32'hFFFFFFFE);
    add(0, 1, 0, 4, 1, 4, 1, 0, wf, 32'hFFFFFFFE);
    add(0, 1, 0, 4, 1, 5, 1, 0, wf, 32'hFFFFFFFE);
    add(0, 1, 0, 4, 1, 6, 1, 0, wf, 32'hFFFFFFFE);
    add(1, 1, 0, 4, 0, 0, 0, 0, wf, 32'hFFFFFFFE);
    repeat (5) add(0, 0, 0, 0, 0, 0, 0, 0, NOP, 0);
    fetch_rows(32'h0, NOP, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, w0, 0);
    add(0, 1, 0, 4, 1, 4, 1, 0, w0, 0);
    add(0, 1, 0, 4, 1, 5, 1, 0, w0, 0);
    add(0, 0, 0, 4, 1, 6, 1, 0, w0, 0);
    add(0, 0, 0, 4, 0, 0, 0, 0, w0, 0);

    for (int n = 0; n < tbl.size(); n++) begin
      rst = tbl[n].r; ce = tbl[n].c; flush = tbl[n].f; pc = tbl[n].p;
      #1;
      compare_outputs($sformatf("vec%0d", n), tbl[n].rd, tbl[n].a, tbl[n].st, tbl[n].v,
                      tbl[n].i, tbl[n].ip);
      @(posedge clk); #1;
    end

    rst = 1; ce = 0; flush = 0;
    @(posedge clk); #1;
    phase = -1; m_pc = 0; m_inst = NOP; m_ipc = 0;

    for (int n = 0; n < 3000; n++) begin
      r_r = ($urandom_range(0, 199) == 0);
      r_c = ($urandom_range(0, 99) < 88);
      r_f = ($urandom_range(0, 99) < 4);
      r_p = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + $urandom_range(0, 3)) : $urandom;
      rst = r_r; ce = r_c; flush = r_f; pc = r_p;
      #1;
      e_rd = 0; e_a = 0; e_st = 0; e_v = 0;
      if (!r_r) begin
        if (phase < 0) begin
          if (r_c && !r_f) begin e_rd = 1; e_a = r_p; e_st = 1; end
        end else if (phase <= 3) begin
          e_rd = 1; e_a = m_pc + 32'(phase); e_st = 1;
        end else if (phase == 4) begin
          e_st = 1;
        end else begin
          e_v = !r_f;
        end
      end
      compare_outputs($sformatf("rnd%0d", n), e_rd, e_a, e_st, e_v, m_inst, m_ipc);

      if (r_r) begin
        phase = -1; m_inst = NOP; m_ipc = 0;
      end else if (phase < 0) begin
        if (r_c && !r_f) begin phase = 1; m_pc = r_p; end
        else if (r_f) m_inst = NOP;
      end else if (phase <= 4) begin
        if (r_f || !r_c) begin
          phase = -1;
          if (r_f) m_inst = NOP;
        end else begin
          if (phase == 4) begin m_inst = word_at(m_pc); m_ipc = m_pc; end
          phase++;
        end
      end else begin
        phase = -1;
        if (r_f) m_inst = NOP;
      end
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch_port.md
Name: inst_fetch_port

Overview:
- Responder end of the instruction-fetch request interface.
- Accepts the fetch address (pc) and chip-enable (ce) from the PC register and reads four bytes from a byte-wide synchronous instruction memory.
- Assembles the bytes into a 32-bit little-endian instruction and presents it to the IF/ID stage.
- Raises a stall request so the PC is held while a fetch is in flight; branch redirects abort an in-flight fetch.

Parameters:
- ADDR_W, 32, width of fetch and memory addresses.
- NOP_INST, 32'h00000013, value of inst_o after reset and after a flush (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset (1 = reset, sampled on the rising clk edge).
- pc_i  input  ADDR_W  fetch address from the PC register.
- ce_i  input  1  fetch enable; 1 = request valid.
- flush_i  input  1  branch redirect or pipeline flush; aborts the current fetch.
- mem_addr_o  output  ADDR_W  byte address to instruction memory.
- mem_rd_o  output  1  memory read strobe.
- mem_data_i  input  8  read byte; valid exactly one cycle after the address/strobe cycle.
- inst_o  output  32  assembled instruction.
- inst_pc_o  output  ADDR_W  address the instruction was fetched from.
- inst_valid_o  output  1  one-cycle pulse: inst_o/inst_pc_o are fresh.
- stallreq_o  output  1  request to the stall controller to hold the PC and IF stage.

Behaviour:
- States: IDLE, S1, S2, S3, S4, DONE. Held in a state register.
- Reset: state=IDLE; inst_o=NOP_INST; inst_pc_o=0; byte buffer=0. All outputs are 0 except inst_o. Reset has priority over every other input, including mid-fetch.
- IDLE, ce_i=0: mem_rd_o=0, stallreq_o=0; stay in IDLE.
- IDLE, ce_i=1, flush_i=0:
  - mem_addr_o=pc_i, mem_rd_o=1.
  - Latch pc_i into the internal fetch address register.
  - Next state S1.
- S1/S2/S3:
  - mem_addr_o = latched pc + 1, +2, +3 respectively; mem_rd_o=1.
  - Capture mem_data_i as byte 0, 1, 2 respectively.
  - Advance to the next state.
- S4: mem_rd_o=0; capture mem_data_i as byte 3; next state DONE.
- DONE:
  - inst_o = {b3,b2,b1,b0}, registered on entry to DONE. inst_pc_o = latched pc.
  - inst_valid_o = 1 for this single cycle; stallreq_o = 0 so the PC advances on this edge.
  - Next state IDLE.
- stallreq_o:
  - 1 in IDLE when ce_i=1 and flush_i=0.
  - 1 in S1–S4.
  - 0 in DONE and in idle-without-request.
  - Combinational from state and inputs.
- Address arithmetic: latched pc + k is computed modulo 2^ADDR_W (wraps at the top of the address space). Alignment is not checked.
- mem_addr_o is don't-care when mem_rd_o=0; it is driven to 0 in that case.
- Latency: 6 cycles from request acceptance (IDLE with ce_i=1) to the inst_valid_o pulse. Back-to-back fetch throughput is one instruction per 6 cycles.
- flush_i=1 in any state:
  - Next state IDLE; no new request is accepted that cycle.
  - inst_valid_o is forced to 0 (combinational, including in DONE).
  - inst_o is set to NOP_INST; partially captured bytes are discarded.
- ce_i falling to 0 during S1–S4 is treated as an abort, identical to flush_i except inst_o is unchanged.
- Simultaneous flush_i and ce_i in IDLE: flush wins; nothing is issued.
- inst_o and inst_pc_o hold their values between DONE pulses.

Test Plan:
- Reset, then deassert rst with ce_i=0 for 3 cycles -> inst_o=32'h00000013, inst_valid_o=0, stallreq_o=0, mem_rd_o=0.
- Memory[0..3]=13 05 50 00; pc_i=0, ce_i=1 -> mem_addr_o sequence 0,1,2,3. On the 6th cycle inst_valid_o=1, inst_o=32'h00500513, inst_pc_o=0. stallreq_o is 1 for cycles 1–5 and 0 in cycle 6.
- Back-to-back: pc_i=0, then pc_i=4 after DONE; Memory[4..7]=93 05 A0 00 -> second pulse exactly 6 cycles after the first with inst_o=32'h00A00593, inst_pc_o=4.
- flush_i=1 while in S2 -> next cycle state is IDLE, no inst_valid_o pulse, inst_o=32'h00000013. A new request at pc_i=32'h40 then completes normally with inst_pc_o=32'h40.
- pc_i=32'hFFFFFFFE -> mem_addr_o sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001 (wrap-around).
- rst asserted in S3 -> next cycle all outputs are at reset values. No pulse occurs until a fresh request completes.
